lifo_fifo_buffer: RTL

- Parametrised successor to the single-mode stack buffer: one storage array serving as a LIFO stack or a FIFO queue, selected at run time.
- Adds true full/empty/occupancy reporting, defined simultaneous read/write in both modes, synchronous flush and sticky overflow/underflow error flags.
- Sits between a producer and a consumer on a single clock domain and buffers DATA_W-bit words.

---
 rtl/lifo_fifo_buffer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lifo_fifo_buffer.sv
// Run-time selectable LIFO/FIFO buffer over a single storage array.
// Reports occupancy, full and empty, and keeps sticky overflow/underflow flags.
module lifo_fifo_buffer #(
  parameter  int DEPTH  = 6,
  parameter  int DATA_W = 10,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mode,
  input  logic              write,
  input  logic [DATA_W-1:0] datain,
  input  logic              read,
  input  logic              flush,
  input  logic              clear_err,
  output logic [DATA_W-1:0] dataout,
  output logic              val,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              mode_q,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              val_q, val_d;
  logic              mode_lat_q, mode_lat_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              is_full, is_empty;
  logic [PTR_W-1:0]  wr_next, rd_next, top_idx;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic              push_acc;
  logic              ovf_evt, unf_evt;

  assign is_full  = (count_q == CNT_FULL);
  assign is_empty = (count_q == '0);

  assign wr_next = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
  assign rd_next = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
  // Stack top sits just below the write pointer, wrapping at slot 0.
  assign top_idx = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dataout_d = dataout_q;
    val_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    push_acc  = 1'b0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case ({write, read})
        2'b10: begin
          if (!is_full) begin
            mem_we   = 1'b1;
            push_acc = 1'b1;
            wr_ptr_d = wr_next;
            count_d  = count_q + CNT_W'(1);
          end else begin
            ovf_evt = 1'b1;
          end
        end
        2'b01: begin
          if (!is_empty) begin
            val_d   = 1'b1;
            count_d = count_q - CNT_W'(1);
            if (mode_lat_q) begin
              dataout_d = mem[top_idx];
              wr_ptr_d  = top_idx;
            end else begin
              dataout_d = mem[rd_ptr_q];
              rd_ptr_d  = rd_next;
            end
          end else begin
            unf_evt = 1'b1;
          end
        end
        2'b11: begin
          if (is_empty) begin
            // No bypass: the word is stored and the read counts as an underflow.
            mem_we   = 1'b1;
            push_acc = 1'b1;
            wr_ptr_d = wr_next;
            count_d  = CNT_W'(1);
            unf_evt  = 1'b1;
          end else if (mode_lat_q) begin
            dataout_d = mem[top_idx];
            mem_we    = 1'b1;
            mem_waddr = top_idx;
            val_d     = 1'b1;
          end else begin
            dataout_d = mem[rd_ptr_q];
            mem_we    = 1'b1;
            push_acc  = 1'b1;
            wr_ptr_d  = wr_next;
            rd_ptr_d  = rd_next;
            val_d     = 1'b1;
          end
        end
        default: ;
      endcase
    end

    mode_lat_d  = (is_empty && !push_acc) ? mode : mode_lat_q;
    // A fresh error in the same cycle as clear_err keeps its flag set.
    overflow_d  = (overflow_q  & ~clear_err) | ovf_evt;
    underflow_d = (underflow_q & ~clear_err) | unf_evt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dataout_q   <= '0;
      val_q       <= 1'b0;
      mode_lat_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dataout_q   <= dataout_d;
      val_q       <= val_d;
      mode_lat_q  <= mode_lat_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= datain;
    end
  end

  assign dataout   = dataout_q;
  assign val       = val_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign count     = count_q;
  assign mode_q    = mode_lat_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
